// File: rtl/ram_master_if.sv
// ram_master_if: processor request/response and SDRAM-side signal bundle.
// The master modport is the ram_master view; slave is the processor/SDRAM environment.
interface ram_master_if;
  logic        req_valid;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [23:0] ram_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic        ram_rd_en;
  logic        ram_busy;
  logic [15:0] ram_rd_data;
  logic        ram_rd_ready;
  logic        ram_rd_ack;
  logic [7:0]  stray_count;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, ram_busy, ram_rd_data, ram_rd_ready,
    output req_ready, resp_valid, resp_data, resp_err, ram_addr, ram_wr_data,
           ram_wr_en, ram_rd_en, ram_rd_ack, stray_count
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, ram_busy, ram_rd_data, ram_rd_ready,
    input  req_ready, resp_valid, resp_data, resp_err, ram_addr, ram_wr_data,
           ram_wr_en, ram_rd_en, ram_rd_ack, stray_count
  );
endinterface

// File: rtl/ram_master.sv
// ram_master: sequences single processor requests onto the SDRAM request FIFOs.
// Optional read-wait timeout is enabled by defining RAM_MASTER_TIMEOUT_EN.
module ram_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  ram_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_r;
  state_t      state_next_s;
  logic        we_r;
  logic [23:0] ram_addr_r;
  logic [15:0] ram_wr_data_r;
  logic [15:0] resp_data_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [7:0]  stray_count_r;

  logic        accept_s;
  logic        req_ready_s;
  logic        wr_en_s;
  logic        rd_en_s;
  logic        rd_ack_s;
  logic        stray_s;
  logic        rsp_load_s;
  logic        rsp_err_s;
  logic        timeout_s;

`ifdef RAM_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_r;

  assign timeout_s = (wait_cnt_r == TIMEOUT_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and combinational handshake/enable decode; everything is forced low in reset
  always_comb begin
    state_next_s = state_r;
    req_ready_s  = 1'b0;
    accept_s     = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    rd_ack_s     = 1'b0;
    stray_s      = 1'b0;
    rsp_load_s   = 1'b0;
    rsp_err_s    = 1'b0;
    if (rst) begin
      case (state_r)
        IDLE: begin
          req_ready_s = !bus.ram_busy;
          accept_s    = !bus.ram_busy && bus.req_valid;
          stray_s     = bus.ram_rd_ready;
          rd_ack_s    = bus.ram_rd_ready;
          if (accept_s) begin
            state_next_s = ISSUE;
          end else begin
            state_next_s = IDLE;
          end
        end
        ISSUE: begin
          stray_s  = bus.ram_rd_ready;
          rd_ack_s = bus.ram_rd_ready;
          if (!bus.ram_busy) begin
            wr_en_s      = we_r;
            rd_en_s      = !we_r;
            state_next_s = we_r ? IDLE : WAIT;
          end else begin
            state_next_s = ISSUE;
          end
        end
        WAIT: begin
          // Data on the timeout cycle wins over the timeout
          if (bus.ram_rd_ready) begin
            rd_ack_s     = 1'b1;
            rsp_load_s   = 1'b1;
            state_next_s = IDLE;
          end else if (timeout_s) begin
            rsp_load_s   = 1'b1;
            rsp_err_s    = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = WAIT;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, response capture and stray-word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r          <= 1'b0;
      ram_addr_r    <= 24'h000000;
      ram_wr_data_r <= 16'h0000;
      resp_data_r   <= 16'h0000;
      resp_valid_r  <= 1'b0;
      resp_err_r    <= 1'b0;
      stray_count_r <= 8'h00;
    end else begin
      if (accept_s) begin
        we_r          <= bus.req_we;
        ram_addr_r    <= bus.req_addr;
        ram_wr_data_r <= bus.req_wdata;
      end
      resp_valid_r <= rsp_load_s;
      if (rsp_load_s) begin
        resp_data_r <= rsp_err_s ? 16'hFFFF : bus.ram_rd_data;
        resp_err_r  <= rsp_err_s;
      end
      if (stray_s && (stray_count_r != 8'hFF)) begin
        stray_count_r <= stray_count_r + 8'd1;
      end
    end
  end

`ifdef RAM_MASTER_TIMEOUT_EN
  // Read-wait counter: restarts on WAIT entry, advances on each empty WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= 16'h0000;
    end else if ((state_r == ISSUE) && (state_next_s == WAIT)) begin
      wait_cnt_r <= 16'h0000;
    end else if ((state_r == WAIT) && !bus.ram_rd_ready && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end
  end
`endif

  assign bus.req_ready   = req_ready_s;
  assign bus.ram_wr_en   = wr_en_s;
  assign bus.ram_rd_en   = rd_en_s;
  assign bus.ram_rd_ack  = rd_ack_s;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_wr_data = ram_wr_data_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_data   = resp_data_r;
  assign bus.resp_err    = resp_err_r;
  assign bus.stray_count = stray_count_r;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized scoreboard bench for ram_master with an SDRAM FIFO emulator.
module tb_ram_master;

  localparam int TO_CYCLES = 8;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] data;
  } op_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } rsp_t;

  logic clk;
  logic rst;
  ram_master_if bus();

  ram_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int ack_cnt = 0;
  int resp_cnt = 0;
  int stray_exp = 0;
  int force_delay = -1;
  int acc_cyc = 0;

  op_t  op_q[$];
  rsp_t rsp_q[$];
  logic [15:0] ref_mem [logic [23:0]];
  logic [15:0] emu_mem [logic [23:0]];

  logic emu_ready, stray_req, busy_dir, busy_rand, rand_busy_en, emu_mute;
  logic [15:0] emu_data;

  assign bus.ram_rd_ready = emu_ready | stray_req;
  assign bus.ram_rd_data  = emu_data;
  assign bus.ram_busy     = busy_dir | busy_rand;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input logic [23:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and record its expected SDRAM op and response
  task automatic do_req(input logic we, input logic [23:0] addr, input logic [15:0] data,
                        input logic push_resp);
    logic ok;
    op_t o;
    rsp_t r;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      acc_cyc = cyc;
      o.we = we; o.addr = addr; o.data = data;
      op_q.push_back(o);
      if (we) begin
        ref_mem[addr] = data;
      end else if (push_resp) begin
        r.data = ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr);
        r.err  = 1'b0;
        r.due  = (force_delay >= 0) ? acc_cyc + 2 + force_delay : -1;
        rsp_q.push_back(r);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((rsp_q.size() != 0) && (k < 200)) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (rsp_q.size() != 0) check("drain_timeout", rsp_q.size(), 32'd0);
  endtask

  // SDRAM emulator: stores writes, answers reads after a delay, pops on ack
  initial begin
    logic will_pop, pend;
    int pend_delay;
    logic [15:0] pend_data;
    emu_ready = 1'b0;
    emu_data  = 16'h0000;
    pend = 1'b0;
    pend_delay = 0;
    pend_data = 16'h0000;
    forever begin
      @(negedge clk);
      will_pop = emu_ready && bus.ram_rd_ack;
      if (bus.ram_wr_en) emu_mem[bus.ram_addr] = bus.ram_wr_data;
      if (bus.ram_rd_en && !emu_mute) begin
        pend = 1'b1;
        pend_data = emu_mem.exists(bus.ram_addr) ? emu_mem[bus.ram_addr] : init_word(bus.ram_addr);
        pend_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
      end
      @(posedge clk);
      #1;
      if (will_pop) emu_ready = 1'b0;
      if (pend && !emu_ready) begin
        if (pend_delay == 0) begin
          emu_ready = 1'b1;
          emu_data  = pend_data;
          pend = 1'b0;
        end else begin
          pend_delay--;
        end
      end
    end
  end

  // Random backpressure source
  initial begin
    busy_rand = 1'b0;
    forever begin
      tick();
      busy_rand = rand_busy_en && ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: SDRAM ops, responses and ack pulses against the scoreboard
  initial begin
    op_t o;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (bus.ram_wr_en && bus.ram_rd_en) check("both_enables", 32'd1, 32'd0);
      if (bus.ram_rd_ack) ack_cnt++;
      if (bus.ram_wr_en || bus.ram_rd_en) begin
        if (bus.ram_wr_en) wr_cnt++; else rd_cnt++;
        if (op_q.size() == 0) begin
          check("unexpected_op", 32'd1, 32'd0);
        end else begin
          o = op_q.pop_front();
          check("op_we", {31'd0, bus.ram_wr_en}, {31'd0, o.we});
          check("op_addr", {8'd0, bus.ram_addr}, {8'd0, o.addr});
          if (o.we) check("op_wdata", {16'd0, bus.ram_wr_data}, {16'd0, o.data});
        end
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        if (!bus.ram_busy) check("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
        if (rsp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("resp_data", {16'd0, bus.resp_data}, {16'd0, r.data});
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, r.err});
          if (r.due >= 0) check("resp_latency", cyc, r.due);
        end
      end
    end
  end

  // Directed and random stimulus
  initial begin
    int w0, r0, a0;
    rsp_t t;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 24'h0;
    bus.req_wdata = 16'h0;
    stray_req = 1'b0;
    busy_dir = 1'b0;
    rand_busy_en = 1'b0;
    emu_mute = 1'b0;
    emu_mem[24'h000020] = 16'h1234;
    ref_mem[24'h000020] = 16'h1234;
    repeat (3) tick();
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_ram_addr", {8'd0, bus.ram_addr}, 32'd0);
    check("rst_stray", {24'd0, bus.stray_count}, 32'd0);
    rst = 1'b1;
    tick();

    // Single write
    w0 = wr_cnt; r0 = resp_cnt;
    do_req(1'b1, 24'h000010, 16'hBEEF, 1'b1);
    repeat (3) tick();
    check("wr_pulses", wr_cnt - w0, 32'd1);
    check("wr_no_resp", resp_cnt - r0, 32'd0);

    // Read with data after 5 cycles, then minimum-latency read
    a0 = ack_cnt;
    force_delay = 5;
    do_req(1'b0, 24'h000020, 16'h0000, 1'b1);
    drain();
    check("rd_acks", ack_cnt - a0, 32'd1);
    force_delay = 0;
    do_req(1'b0, 24'h000010, 16'h0000, 1'b1);
    drain();
    force_delay = -1;

    // Backpressure during ISSUE
    w0 = wr_cnt;
    do_req(1'b1, 24'h000033, 16'hC0DE, 1'b1);
    busy_dir = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("busy_no_en", {31'd0, bus.ram_wr_en}, 32'd0);
      check("busy_no_ready", {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    busy_dir = 1'b0;
    tick();
    check("busy_one_pulse", wr_cnt - w0, 32'd1);
    check("busy_addr", {8'd0, bus.ram_addr}, 32'h000033);

    // Stray words while idle
    a0 = ack_cnt;
    stray_req = 1'b1;
    repeat (3) tick();
    stray_req = 1'b0;
    stray_exp = (stray_exp + 3 > 255) ? 255 : stray_exp + 3;
    check("stray_acks", ack_cnt - a0, 32'd3);
    check("stray_3", {24'd0, bus.stray_count}, stray_exp);
    stray_req = 1'b1;
    repeat (300) tick();
    stray_req = 1'b0;
    stray_exp = (stray_exp + 300 > 255) ? 255 : stray_exp + 300;
    check("stray_sat", {24'd0, bus.stray_count}, stray_exp);

    // Randomized mixed traffic with backpressure
    rand_busy_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), {21'd0, 3'($urandom_range(0, 7))},
             16'($urandom), 1'b1);
    end
    drain();
    rand_busy_en = 1'b0;
    repeat (2) tick();

    // Read that never gets data
    emu_mute = 1'b1;
`ifdef RAM_MASTER_TIMEOUT_EN
    do_req(1'b0, 24'h000044, 16'h0000, 1'b0);
    t.data = 16'hFFFF; t.err = 1'b1; t.due = acc_cyc + 1 + TO_CYCLES;
    rsp_q.push_back(t);
    drain();
    do_req(1'b0, 24'h000055, 16'h0000, 1'b0);
    repeat (3) tick();
`else
    t.due = 0;
    do_req(1'b0, 24'h000055, 16'h0000, 1'b0);
    r0 = resp_cnt;
    repeat (20) tick();
    check("no_timeout_resp", resp_cnt - r0, {31'd0, 1'b0} + t.due);
`endif

    // Reset in the middle of WAIT
    #2;
    stray_req = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_addr", {8'd0, bus.ram_addr}, 32'd0);
    check("mid_rst_wdata", {16'd0, bus.ram_wr_data}, 32'd0);
    check("mid_rst_rdata", {16'd0, bus.resp_data}, 32'd0);
    check("mid_rst_flags", {28'd0, bus.resp_valid, bus.resp_err, bus.req_ready, bus.ram_rd_ack},
          32'd0);
    check("mid_rst_en", {30'd0, bus.ram_wr_en, bus.ram_rd_en}, 32'd0);
    check("mid_rst_stray", {24'd0, bus.stray_count}, 32'd0);
    stray_req = 1'b0;
    tick();
    rst = 1'b1;
    stray_exp = 0;
    emu_mute = 1'b0;
    r0 = resp_cnt;
    stray_req = 1'b1;
    repeat (2) tick();
    stray_req = 1'b0;
    stray_exp = 2;
    check("post_rst_stray", {24'd0, bus.stray_count}, stray_exp);
    repeat (5) tick();
    check("post_rst_no_resp", resp_cnt - r0, 32'd0);
    check("ops_left", op_q.size(), 32'd0);
    check("resps_left", rsp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
